ex_writeback_regfile: RTL and testbench
=======================================

// Module: ex_writeback_regfile
// PURPOSE
//  Receives the EX-stage result triple (dest addr, write enable, data), carries it through the
//  EX/MEM and MEM/WB pipeline latches, retires it into the 32x32 GPR array, and serves ID's two
//  operand read ports with full forwarding from all in-flight results.
//  Sits between ex (producer of results) and id (consumer of reg1/reg2 operands).
// PARAMETERS
//  DATA_W   32  GPR / result width
//  ADDR_W   5   register address width (2**ADDR_W registers)
//  FWD_EX   1   1: forward the same-cycle EX result to read ports; 0: forward latches only
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst          in   1       asynchronous, active-high reset (`RstEnable)
//  stall_i      in   1       1: hold EX/MEM and MEM/WB latches (no advance)
//  ex_wd_i      in   ADDR_W  EX result destination register
//  ex_wreg_i    in   1       EX result write enable
//  ex_wdata_i   in   DATA_W  EX result data
//  re1_i        in   1       read port 1 enable
//  raddr1_i     in   ADDR_W  read port 1 address
//  rdata1_o     out  DATA_W  read port 1 data (combinational)
//  re2_i        in   1       read port 2 enable
//  raddr2_i     in   ADDR_W  read port 2 address
//  rdata2_o     out  DATA_W  read port 2 data (combinational)
//  wb_wreg_o    out  1       retire strobe: MEM/WB entry is writing the array this cycle
//  wb_wd_o      out  ADDR_W  retiring register address
//  wb_wdata_o   out  DATA_W  retiring data
// BEHAVIOUR
//  - Reset (async, rst=1): both latches cleared (wreg=0, wd=`NOPRegAddr, wdata=`ZeroWord);
//    all 32 GPRs cleared to 0; rdata1_o/rdata2_o=0; wb_* outputs=0. Held while rst=1.
//  - Advance (stall_i=0): edge N captures ex_* into EX/MEM; EX/MEM moves to MEM/WB.
//  - Stall (stall_i=1): both latches hold; MEM/WB entry keeps writing (idempotent).
//  - Retire: when MEM/WB.wreg=1 and MEM/WB.wd!=0, array[wd] <= wdata on the rising edge.
//    Result presented at ex_* on cycle N is in the array after edge N+2 (3-edge latency).
//  - Writes to register 0 are dropped at retire; register 0 reads always 0.
//  - Read (per port, combinational), first match wins:
//      re=0 -> 0 ; raddr=0 -> 0 ;
//      FWD_EX && ex_wreg_i && ex_wd_i==raddr -> ex_wdata_i ;
//      EX/MEM.wreg && EX/MEM.wd==raddr -> EX/MEM.wdata ;
//      MEM/WB.wreg && MEM/WB.wd==raddr -> MEM/WB.wdata ;
//      else array[raddr].
//    Youngest producer always wins; both ports resolve independently, same address allowed.
//  - wb_* outputs mirror the MEM/WB latch (wb_wreg_o=0 when wd=0).
//  - ex_wreg_i=0 entries flow through as bubbles: never write, never forward.
//  - Reset mid-flight discards both latch contents; nothing partially retires.
// STRUCTURE
//  - Shared macros from precompiled.v: `RegBus, `RegAddrBus, `RegNum, `ZeroWord, `RstEnable,
//    `WriteEnable, `ReadEnable, `NOPRegAddr. No new typedefs.
//  - One sub-module: gpr_array (32xDATA_W storage, one write port, two raw read ports, async
//    reset). Top level holds the two latches and the forwarding muxes.
// TESTING
//  1 Reset: rst=1 mid-stream with EX/MEM holding r5=0x1234 -> after release r5 reads 0,
//    wb_wreg_o=0, no retire.
//  2 Latency: ex r3<=0xDEADBEEF cycle 0, then bubbles, FWD_EX=1 -> port1(r3)=0xDEADBEEF on
//    cycles 0,1,2 (EX, EX/MEM, MEM/WB) and from array thereafter; wb_wreg_o=1 only in cycle 2.
//  3 Priority: r7<=1, r7<=2, r7<=3 on consecutive cycles -> cycle 2 port1(r7)=3, cycle 3
//    reads 3 from EX/MEM while MEM/WB retires 2; final array r7=3.
//  4 Register 0: ex r0<=0xFFFFFFFF with wreg=1 -> port reads 0 every cycle, array r0 stays 0,
//    wb_wreg_o=0.
//  5 Stall: r9<=0x55 then stall_i=1 for 3 cycles -> latches frozen, port2(r9)=0x55 throughout,
//    retire completes 2 edges after stall_i falls.
//  6 Enables/dual read: re1=0,re2=1 both raddr=r4 (r4=0xA5A5A5A5) -> rdata1_o=0,
//    rdata2_o=0xA5A5A5A5; ex_wreg_i=0 with ex_wd_i=r4 never alters r4.

Source files
------------

// File: rtl/ex_writeback_regfile_pkg.sv
// rtl/ex_writeback_regfile_pkg.sv - shared widths and enable levels for the writeback/regfile slice
package ex_writeback_regfile_pkg;

   localparam int   REG_BUS_W    = 32;
   localparam int   REG_ADDR_W   = 5;
   localparam logic WRITE_ENABLE = 1'b1;
   localparam logic READ_ENABLE  = 1'b1;

endpackage

// File: rtl/ex_writeback_regfile_gpr_array.sv
// rtl/ex_writeback_regfile_gpr_array.sv - GPR storage: one write port, two raw read ports
module ex_writeback_regfile_gpr_array
   import ex_writeback_regfile_pkg::*;
#(
   parameter int DATA_W = REG_BUS_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2
);

   localparam int NREGS = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [NREGS];

   // Register 0 is never written so it stays at its reset value of zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we == WRITE_ENABLE && waddr != '0) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = regs[raddr1];
   assign rdata2 = regs[raddr2];

endmodule

// File: rtl/ex_writeback_regfile.sv
// rtl/ex_writeback_regfile.sv - EX/MEM and MEM/WB result latches, GPR retire and forwarding read ports
module ex_writeback_regfile
   import ex_writeback_regfile_pkg::*;
#(
   parameter int DATA_W = REG_BUS_W,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int FWD_EX = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic [ADDR_W-1:0] ex_wd_i,
   input  logic              ex_wreg_i,
   input  logic [DATA_W-1:0] ex_wdata_i,
   input  logic              re1_i,
   input  logic [ADDR_W-1:0] raddr1_i,
   output logic [DATA_W-1:0] rdata1_o,
   input  logic              re2_i,
   input  logic [ADDR_W-1:0] raddr2_i,
   output logic [DATA_W-1:0] rdata2_o,
   output logic              wb_wreg_o,
   output logic [ADDR_W-1:0] wb_wd_o,
   output logic [DATA_W-1:0] wb_wdata_o
);

   logic              exmem_wreg;
   logic [ADDR_W-1:0] exmem_wd;
   logic [DATA_W-1:0] exmem_wdata;
   logic              memwb_wreg;
   logic [ADDR_W-1:0] memwb_wd;
   logic [DATA_W-1:0] memwb_wdata;
   logic              retire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exmem_wreg  <= 1'b0;
         exmem_wd    <= '0;
         exmem_wdata <= '0;
         memwb_wreg  <= 1'b0;
         memwb_wd    <= '0;
         memwb_wdata <= '0;
      end else if (!stall_i) begin
         exmem_wreg  <= ex_wreg_i;
         exmem_wd    <= ex_wd_i;
         exmem_wdata <= ex_wdata_i;
         memwb_wreg  <= exmem_wreg;
         memwb_wd    <= exmem_wd;
         memwb_wdata <= exmem_wdata;
      end
   end

   // A held MEM/WB entry keeps rewriting the same value during a stall, which is harmless.
   assign retire     = (memwb_wreg == WRITE_ENABLE) && (memwb_wd != '0);
   assign wb_wreg_o  = retire;
   assign wb_wd_o    = memwb_wd;
   assign wb_wdata_o = memwb_wdata;

   logic [1:0]        re;
   logic [ADDR_W-1:0] raddr [2];
   logic [DATA_W-1:0] raw   [2];
   logic [DATA_W-1:0] rdata [2];

   assign re       = {re2_i, re1_i};
   assign raddr[0] = raddr1_i;
   assign raddr[1] = raddr2_i;

   ex_writeback_regfile_gpr_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_gpr_array (
      .clk    (clk),
      .rst    (rst),
      .we     (retire),
      .waddr  (memwb_wd),
      .wdata  (memwb_wdata),
      .raddr1 (raddr[0]),
      .rdata1 (raw[0]),
      .raddr2 (raddr[1]),
      .rdata2 (raw[1])
   );

   // Checked youngest-first so the most recent producer of a register always wins.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata[p] = raw[p];
         if (rst || re[p] != READ_ENABLE || raddr[p] == '0) begin
            rdata[p] = '0;
         end else if (FWD_EX != 0 && ex_wreg_i == WRITE_ENABLE && ex_wd_i == raddr[p]) begin
            rdata[p] = ex_wdata_i;
         end else if (exmem_wreg == WRITE_ENABLE && exmem_wd == raddr[p]) begin
            rdata[p] = exmem_wdata;
         end else if (memwb_wreg == WRITE_ENABLE && memwb_wd == raddr[p]) begin
            rdata[p] = memwb_wdata;
         end
      end
   end

   assign rdata1_o = rdata[0];
   assign rdata2_o = rdata[1];

endmodule

// File: tb/tb_ex_writeback_regfile.sv
// tb/tb_ex_writeback_regfile.sv - directed scoreboard bench for ex_writeback_regfile
module tb_ex_writeback_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic [4:0]  ex_wd_i;
   logic        ex_wreg_i;
   logic [31:0] ex_wdata_i;
   logic        re1_i;
   logic [4:0]  raddr1_i;
   logic [31:0] rdata1_o;
   logic        re2_i;
   logic [4:0]  raddr2_i;
   logic [31:0] rdata2_o;
   logic        wb_wreg_o;
   logic [4:0]  wb_wd_o;
   logic [31:0] wb_wdata_o;

   localparam int RD1 = 0, RD2 = 1, WBW = 2, WBD = 3, WBDATA = 4;

   typedef struct {
      int          which;
      logic [31:0] val;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   ex_writeback_regfile #(
      .DATA_W (32),
      .ADDR_W (5),
      .FWD_EX (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall_i    (stall_i),
      .ex_wd_i    (ex_wd_i),
      .ex_wreg_i  (ex_wreg_i),
      .ex_wdata_i (ex_wdata_i),
      .re1_i      (re1_i),
      .raddr1_i   (raddr1_i),
      .rdata1_o   (rdata1_o),
      .re2_i      (re2_i),
      .raddr2_i   (raddr2_i),
      .rdata2_o   (rdata2_o),
      .wb_wreg_o  (wb_wreg_o),
      .wb_wd_o    (wb_wd_o),
      .wb_wdata_o (wb_wdata_o)
   );

   task automatic push_exp(input int which, input logic [31:0] val, input string tag);
      exp_t e;
      e.which = which;
      e.val   = val;
      e.tag   = tag;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] observe(input int which);
      case (which)
         RD1:     return rdata1_o;
         RD2:     return rdata2_o;
         WBW:     return {31'b0, wb_wreg_o};
         WBD:     return {27'b0, wb_wd_o};
         default: return wb_wdata_o;
      endcase
   endfunction

   task automatic check_all();
      exp_t        e;
      logic [31:0] o;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = observe(e.which);
         compared++;
         assert (o === e.val) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
         end
      end
   endtask

   task automatic drive(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
      ex_wd_i    = wd;
      ex_wreg_i  = wreg;
      ex_wdata_i = wdata;
   endtask

   initial begin
      rst = 1'b1; stall_i = 1'b0;
      drive(5'd0, 1'b0, 32'h0);
      re1_i = 1'b0; raddr1_i = 5'd0; re2_i = 1'b0; raddr2_i = 5'd0;

      // reset state, even with a live EX result matching the read address
      @(negedge clk);
      re1_i = 1'b1; raddr1_i = 5'd5;
      drive(5'd5, 1'b1, 32'h77);
      push_exp(RD1, 32'h0, "rst_rdata1");
      push_exp(WBW, 32'h0, "rst_wb_wreg");
      push_exp(WBD, 32'h0, "rst_wb_wd");
      push_exp(WBDATA, 32'h0, "rst_wb_wdata");
      check_all();

      // 1: reset mid-flight discards the EX/MEM entry
      @(negedge clk);
      rst = 1'b0;
      drive(5'd5, 1'b1, 32'h1234);
      push_exp(RD1, 32'h1234, "t1_ex_fwd");
      check_all();
      @(negedge clk);
      drive(5'd0, 1'b0, 32'h0);
      push_exp(RD1, 32'h1234, "t1_exmem_fwd");
      check_all();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clk);
         push_exp(RD1, 32'h0, $sformatf("t1_r5_after_rst_c%0d", c));
         push_exp(WBW, 32'h0, $sformatf("t1_wb_wreg_c%0d", c));
         check_all();
      end

      // 2: three-edge latency with forwarding from every stage
      raddr1_i = 5'd3;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 0) drive(5'd3, 1'b1, 32'hDEADBEEF);
         else        drive(5'd0, 1'b0, 32'h0);
         push_exp(RD1, 32'hDEADBEEF, $sformatf("t2_rd1_c%0d", c));
         push_exp(WBW, {31'b0, c == 2}, $sformatf("t2_wb_wreg_c%0d", c));
         if (c == 2) begin
            push_exp(WBD, 32'd3, "t2_wb_wd");
            push_exp(WBDATA, 32'hDEADBEEF, "t2_wb_wdata");
         end
         check_all();
      end

      // 3: youngest producer wins
      raddr1_i = 5'd7;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (c < 3) drive(5'd7, 1'b1, 32'(c + 1));
         else       drive(5'd0, 1'b0, 32'h0);
         push_exp(RD1, (c < 3) ? 32'(c + 1) : 32'd3, $sformatf("t3_rd1_c%0d", c));
         push_exp(WBW, {31'b0, (c >= 2 && c <= 4)}, $sformatf("t3_wb_wreg_c%0d", c));
         if (c >= 2 && c <= 4) push_exp(WBDATA, 32'(c - 1), $sformatf("t3_wb_wdata_c%0d", c));
         check_all();
      end

      // 4: register 0 writes are dropped and never forwarded
      raddr1_i = 5'd0; re2_i = 1'b1; raddr2_i = 5'd0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c == 0) drive(5'd0, 1'b1, 32'hFFFFFFFF);
         else        drive(5'd0, 1'b0, 32'h0);
         push_exp(RD1, 32'h0, $sformatf("t4_rd1_c%0d", c));
         push_exp(RD2, 32'h0, $sformatf("t4_rd2_c%0d", c));
         push_exp(WBW, 32'h0, $sformatf("t4_wb_wreg_c%0d", c));
         check_all();
      end

      // 5: stall freezes both latches
      raddr2_i = 5'd9;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (c == 0) drive(5'd9, 1'b1, 32'h55);
         else        drive(5'd0, 1'b0, 32'h0);
         stall_i = (c >= 1 && c <= 3);
         push_exp(RD2, 32'h55, $sformatf("t5_rd2_c%0d", c));
         push_exp(WBW, {31'b0, c == 5}, $sformatf("t5_wb_wreg_c%0d", c));
         if (c == 5) push_exp(WBD, 32'd9, "t5_wb_wd");
         check_all();
      end

      // 6: read enables, dual read of one address, bubbles never write
      raddr1_i = 5'd4; raddr2_i = 5'd4;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (c == 0)      drive(5'd4, 1'b1, 32'hA5A5A5A5);
         else if (c >= 3) drive(5'd4, 1'b0, 32'h00000BAD);
         else             drive(5'd0, 1'b0, 32'h0);
         re1_i = !(c >= 3 && c <= 5);
         push_exp(RD2, 32'hA5A5A5A5, $sformatf("t6_rd2_c%0d", c));
         push_exp(RD1, re1_i ? 32'hA5A5A5A5 : 32'h0, $sformatf("t6_rd1_c%0d", c));
         if (c >= 3) push_exp(WBW, 32'h0, $sformatf("t6_wb_wreg_c%0d", c));
         check_all();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
